// File: rtl/serial_subtractor_ctrl_if.sv
`default_nettype none
// ============================================================================
// serial_subtractor_ctrl_if : start/result handshake bundle for the serial subtractor
// Rev 1.0
// ============================================================================
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 4
) ();
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   answer;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  modport master (
    output start_valid, a, b, result_ready,
    input  start_ready, answer, result_valid, busy
  );

  modport slave (
    input  start_valid, a, b, result_ready,
    output start_ready, answer, result_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// serial_subtractor_ctrl : bit-serial a-b using one shared full-subtractor cell
// Rev 1.0
// ============================================================================
module serial_subtractor_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH:0]   r_answer;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_borrow_nxt;
  logic [WIDTH-1:0] w_diff_nxt;

  assign w_accept     = bus.start_valid && (r_state == ST_IDLE);
  assign w_last       = (r_cnt == c_last_cnt);
  assign w_d          = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
  // LSB-first processing: each new bit enters at the top and slides down
  assign w_diff_nxt   = {w_d, r_diff[WIDTH-1:1]};

  assign bus.start_ready  = (r_state == ST_IDLE);
  assign bus.result_valid = (r_state == ST_DONE);
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.answer       = r_answer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (bus.result_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_answer <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        ST_RUN: begin
          r_borrow <= w_borrow_nxt;
          r_diff   <= w_diff_nxt;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          // answer only changes on completion, so it holds through DONE and after
          if (w_last) begin
            r_answer <= {w_borrow_nxt, w_diff_nxt};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
